// File: rtl/entity_pkg.sv
// Shared definitions for the tank/projectile entity mover and the game controller.
// Contents: command opcode and direction enumerations, mover FSM states and
// the single-cell position step function. The step function works on
// coordinates zero-extended to MAX_AXIS_W bits.
package entity_pkg;

    typedef enum logic [1:0] {
        OP_MOVE      = 2'b00,
        OP_TURN      = 2'b01,
        OP_FIRE      = 2'b10,
        OP_STEP_PROJ = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        COMMIT = 2'b10
    } state_e;

    // Widest coordinate axis the step function supports.
    localparam int unsigned MAX_AXIS_W = 8;

    typedef struct packed {
        logic                  at_edge;
        logic [MAX_AXIS_W-1:0] row;
        logic [MAX_AXIS_W-1:0] col;
    } step_t;

    // One step from (row, col) toward dir. Stepping off the grid flags
    // at_edge and leaves the coordinates unchanged (no wrap-around).
    function automatic step_t step_pos(
        input logic [MAX_AXIS_W-1:0] row,
        input logic [MAX_AXIS_W-1:0] col,
        input dir_e                  dir,
        input logic [MAX_AXIS_W-1:0] max_coord
    );
        step_t s;
        s.at_edge = 1'b0;
        s.row     = row;
        s.col     = col;
        unique case (dir)
            DIR_UP: begin
                if (row == '0) s.at_edge = 1'b1;
                else           s.row = row - MAX_AXIS_W'(1);
            end
            DIR_DOWN: begin
                if (row == max_coord) s.at_edge = 1'b1;
                else                  s.row = row + MAX_AXIS_W'(1);
            end
            DIR_LEFT: begin
                if (col == '0) s.at_edge = 1'b1;
                else           s.col = col - MAX_AXIS_W'(1);
            end
            DIR_RIGHT: begin
                if (col == max_coord) s.at_edge = 1'b1;
                else                  s.col = col + MAX_AXIS_W'(1);
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/entity_mover_grid_step.sv
// grid_step: combinational candidate-cell and edge-condition computation.
// Ports:
//   row, col     current cell
//   dir          step direction (dir_e encoding)
//   next_row_c   candidate row (equals row when at edge)
//   next_col_c   candidate col (equals col when at edge)
//   at_edge_c    the step would leave the grid
module grid_step #(
    parameter int unsigned GRID_BITS = 4
) (
    input  logic [GRID_BITS-1:0] row,
    input  logic [GRID_BITS-1:0] col,
    input  logic [1:0]           dir,
    output logic [GRID_BITS-1:0] next_row_c,
    output logic [GRID_BITS-1:0] next_col_c,
    output logic                 at_edge_c
);
    import entity_pkg::*;

    localparam logic [MAX_AXIS_W-1:0] MAX_COORD = MAX_AXIS_W'((1 << GRID_BITS) - 1);

    step_t step;

    // Evaluate the shared step function on zero-extended coordinates.
    always_comb begin
        step       = step_pos(MAX_AXIS_W'(row), MAX_AXIS_W'(col), dir_e'(dir), MAX_COORD);
        next_row_c = GRID_BITS'(step.row);
        next_col_c = GRID_BITS'(step.col);
        at_edge_c  = step.at_edge;
    end

endmodule

// File: rtl/entity_mover.sv
// entity_mover: tank and projectile state keeper for a square grid game.
// Commands are accepted in IDLE, evaluated in CALC, answered and applied in
// COMMIT (rsp_valid high exactly in COMMIT, two cycles after acceptance).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/cmd_id/cmd_dir opcode, target tank, direction
//   rsp_valid             one-cycle completion pulse
//   rsp_pos/rsp_dir       resulting {row,col} and direction of the entity
//   rsp_blocked/rsp_hit   move/fire refused; projectile struck a tank
//   rsp_victim            index of the struck tank
//   rd_id, rd_*           combinational read port for one tank's state
module entity_mover #(
    parameter int unsigned GRID_BITS = 4,
    parameter int unsigned N_TANKS   = 2,
    parameter int unsigned SCORE_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(N_TANKS)-1:0] cmd_id,
    input  logic [1:0]                 cmd_dir,
    output logic                       rsp_valid,
    output logic [2*GRID_BITS-1:0]     rsp_pos,
    output logic [1:0]                 rsp_dir,
    output logic                       rsp_blocked,
    output logic                       rsp_hit,
    output logic [$clog2(N_TANKS)-1:0] rsp_victim,
    input  logic [$clog2(N_TANKS)-1:0] rd_id,
    output logic [2*GRID_BITS-1:0]     rd_tank_pos,
    output logic [2*GRID_BITS-1:0]     rd_proj_pos,
    output logic                       rd_proj_active,
    output logic [SCORE_W-1:0]         rd_score
);
    import entity_pkg::*;

    localparam int unsigned ID_W  = $clog2(N_TANKS);
    localparam int unsigned POS_W = 2 * GRID_BITS;
    localparam logic [GRID_BITS-1:0] MAX_C     = '1;
    localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;

    state_e state_q, state_d;
    logic   accept;

    op_e             op_q;
    logic [ID_W-1:0] id_q;
    dir_e            dir_q;

    logic [GRID_BITS-1:0] tank_row [N_TANKS];
    logic [GRID_BITS-1:0] tank_col [N_TANKS];
    dir_e                 tank_dir [N_TANKS];
    logic [GRID_BITS-1:0] proj_row [N_TANKS];
    logic [GRID_BITS-1:0] proj_col [N_TANKS];
    dir_e                 proj_dir [N_TANKS];
    logic [N_TANKS-1:0]   proj_active;
    logic [SCORE_W-1:0]   score    [N_TANKS];

    // Projectile liveness after the pending command, applied in COMMIT.
    logic cmt_active;

    logic [GRID_BITS-1:0] step_row, step_col;
    dir_e                 step_dir;
    logic [GRID_BITS-1:0] cand_row, cand_col;
    logic                 cand_edge;

    logic            other_hit;
    logic [ID_W-1:0] other_idx;

    logic [POS_W-1:0] calc_pos;
    dir_e             calc_dir;
    logic             calc_blocked;
    logic             calc_hit;
    logic [ID_W-1:0]  calc_victim;
    logic             calc_active;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: fixed three-cycle command walk.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Source of the single step: the projectile for STEP_PROJ, else the tank
    // heading in the commanded direction.
    always_comb begin
        step_row = tank_row[id_q];
        step_col = tank_col[id_q];
        step_dir = dir_q;
        if (op_q == OP_STEP_PROJ) begin
            step_row = proj_row[id_q];
            step_col = proj_col[id_q];
            step_dir = proj_dir[id_q];
        end
    end

    grid_step #(
        .GRID_BITS (GRID_BITS)
    ) u_grid_step (
        .row        (step_row),
        .col        (step_col),
        .dir        (step_dir),
        .next_row_c (cand_row),
        .next_col_c (cand_col),
        .at_edge_c  (cand_edge)
    );

    // Lowest-index tank other than the commanded one sitting on the candidate cell.
    always_comb begin
        other_hit = 1'b0;
        other_idx = '0;
        for (int unsigned j = 0; j < N_TANKS; j++) begin
            if (!other_hit && (ID_W'(j) != id_q) &&
                (tank_row[j] == cand_row) && (tank_col[j] == cand_col)) begin
                other_hit = 1'b1;
                other_idx = ID_W'(j);
            end
        end
    end

    // Command result. For a projectile that ends its flight (edge or hit)
    // rsp_pos reports the cell where the flight ended.
    always_comb begin
        calc_pos     = {tank_row[id_q], tank_col[id_q]};
        calc_dir     = tank_dir[id_q];
        calc_blocked = 1'b0;
        calc_hit     = 1'b0;
        calc_victim  = '0;
        calc_active  = proj_active[id_q];
        unique case (op_q)
            OP_MOVE: begin
                calc_dir = dir_q;
                if (cand_edge || other_hit) calc_blocked = 1'b1;
                else                        calc_pos = {cand_row, cand_col};
            end
            OP_TURN: begin
                calc_dir = dir_q;
            end
            OP_FIRE: begin
                if (proj_active[id_q]) begin
                    calc_blocked = 1'b1;
                    calc_pos     = {proj_row[id_q], proj_col[id_q]};
                    calc_dir     = proj_dir[id_q];
                end else begin
                    calc_active = 1'b1;
                end
            end
            OP_STEP_PROJ: begin
                if (proj_active[id_q]) begin
                    calc_pos = {proj_row[id_q], proj_col[id_q]};
                    calc_dir = proj_dir[id_q];
                    if (cand_edge) begin
                        calc_active = 1'b0;
                    end else begin
                        calc_pos = {cand_row, cand_col};
                        if (other_hit) begin
                            calc_hit    = 1'b1;
                            calc_victim = other_idx;
                            calc_active = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    // Command capture, response registers and entity state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_MOVE;
            id_q        <= '0;
            dir_q       <= DIR_UP;
            rsp_valid   <= 1'b0;
            rsp_pos     <= '0;
            rsp_dir     <= '0;
            rsp_blocked <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_victim  <= '0;
            cmt_active  <= 1'b0;
            proj_active <= '0;
            for (int unsigned i = 0; i < N_TANKS; i++) begin
                tank_row[i] <= (i % 2 == 0) ? '0 : MAX_C;
                tank_col[i] <= (i % 2 == 0) ? GRID_BITS'(i) : MAX_C - GRID_BITS'(i - 1);
                tank_dir[i] <= (i % 2 == 0) ? DIR_DOWN : DIR_UP;
                proj_row[i] <= '0;
                proj_col[i] <= '0;
                proj_dir[i] <= DIR_UP;
                score[i]    <= '0;
            end
        end else begin
            if (accept) begin
                op_q  <= op_e'(cmd_op);
                id_q  <= cmd_id;
                dir_q <= dir_e'(cmd_dir);
            end

            rsp_valid <= (state_q == CALC);

            if (state_q == CALC) begin
                rsp_pos     <= calc_pos;
                rsp_dir     <= calc_dir;
                rsp_blocked <= calc_blocked;
                rsp_hit     <= calc_hit;
                rsp_victim  <= calc_victim;
                cmt_active  <= calc_active;
            end

            // The registered response is the update to apply.
            if (state_q == COMMIT) begin
                unique case (op_q)
                    OP_MOVE, OP_TURN: begin
                        tank_row[id_q] <= rsp_pos[POS_W-1:GRID_BITS];
                        tank_col[id_q] <= rsp_pos[GRID_BITS-1:0];
                        tank_dir[id_q] <= dir_e'(rsp_dir);
                    end
                    OP_FIRE: begin
                        if (!rsp_blocked) begin
                            proj_row[id_q]    <= rsp_pos[POS_W-1:GRID_BITS];
                            proj_col[id_q]    <= rsp_pos[GRID_BITS-1:0];
                            proj_dir[id_q]    <= dir_e'(rsp_dir);
                            proj_active[id_q] <= 1'b1;
                        end
                    end
                    OP_STEP_PROJ: begin
                        proj_row[id_q]    <= rsp_pos[POS_W-1:GRID_BITS];
                        proj_col[id_q]    <= rsp_pos[GRID_BITS-1:0];
                        proj_active[id_q] <= cmt_active;
                        if (rsp_hit && (score[id_q] != SCORE_MAX))
                            score[id_q] <= score[id_q] + SCORE_W'(1);
                    end
                endcase
            end
        end
    end

    // Read port; an inactive projectile sits on its owner.
    assign rd_tank_pos    = {tank_row[rd_id], tank_col[rd_id]};
    assign rd_proj_active = proj_active[rd_id];
    assign rd_proj_pos    = proj_active[rd_id] ? {proj_row[rd_id], proj_col[rd_id]}
                                               : {tank_row[rd_id], tank_col[rd_id]};
    assign rd_score       = score[rd_id];

endmodule

// File: tb/tb_entity_mover.sv
// Directed scoreboard bench for entity_mover (default parameters).
module tb_entity_mover;

    localparam int unsigned GRID_BITS = 4;
    localparam int unsigned N_TANKS   = 2;
    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned ID_W      = 1;
    localparam int unsigned POS_W     = 2 * GRID_BITS;

    localparam logic [1:0] MV = 2'b00, TN = 2'b01, FR = 2'b10, SP = 2'b11;
    localparam logic [1:0] UP = 2'b00, DN = 2'b01, LT = 2'b10, RT = 2'b11;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ID_W-1:0]   cmd_id;
    logic [1:0]        cmd_dir;
    logic              rsp_valid;
    logic [POS_W-1:0]  rsp_pos;
    logic [1:0]        rsp_dir;
    logic              rsp_blocked;
    logic              rsp_hit;
    logic [ID_W-1:0]   rsp_victim;
    logic [ID_W-1:0]   rd_id;
    logic [POS_W-1:0]  rd_tank_pos;
    logic [POS_W-1:0]  rd_proj_pos;
    logic              rd_proj_active;
    logic [SCORE_W-1:0] rd_score;

    entity_mover #(
        .GRID_BITS (GRID_BITS),
        .N_TANKS   (N_TANKS),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_id         (cmd_id),
        .cmd_dir        (cmd_dir),
        .rsp_valid      (rsp_valid),
        .rsp_pos        (rsp_pos),
        .rsp_dir        (rsp_dir),
        .rsp_blocked    (rsp_blocked),
        .rsp_hit        (rsp_hit),
        .rsp_victim     (rsp_victim),
        .rd_id          (rd_id),
        .rd_tank_pos    (rd_tank_pos),
        .rd_proj_pos    (rd_proj_pos),
        .rd_proj_active (rd_proj_active),
        .rd_score       (rd_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [1:0]       dir;
        logic             blk;
        logic             hit;
        logic [ID_W-1:0]  vic;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns on the falling edge inside COMMIT
    // with cmd_valid still high carrying junk fields.
    task automatic do_cmd(input logic [1:0] op, input logic [ID_W-1:0] id, input logic [1:0] dir,
                          input logic [POS_W-1:0] e_pos, input logic [1:0] e_dir,
                          input logic e_blk, input logic e_hit, input logic [ID_W-1:0] e_vic);
        exp_t e;
        int   n;
        e.pos = e_pos; e.dir = e_dir; e.blk = e_blk; e.hit = e_hit; e.vic = e_vic;
        sb_q.push_back(e);
        cmd_op = op; cmd_id = id; cmd_dir = dir; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_op  = 2'($urandom);
        cmd_id  = ID_W'($urandom);
        cmd_dir = 2'($urandom);
        @(negedge clk);
        chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("calc_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(n), 32'd0);
        e = sb_q.pop_front();
        if (rsp_valid) begin
            chk("rsp_pos",     32'(rsp_pos),     32'(e.pos));
            chk("rsp_dir",     32'(rsp_dir),     32'(e.dir));
            chk("rsp_blocked", 32'(rsp_blocked), 32'(e.blk));
            chk("rsp_hit",     32'(rsp_hit),     32'(e.hit));
            if (e.hit) chk("rsp_victim", 32'(rsp_victim), 32'(e.vic));
            chk("commit_cmd_ready", 32'(cmd_ready), 32'd0);
        end
    endtask

    task automatic check_rd(input logic [ID_W-1:0] id, input logic [POS_W-1:0] t_pos,
                            input logic [POS_W-1:0] p_pos, input logic act, input logic [SCORE_W-1:0] sc);
        cmd_valid = 1'b0;
        @(negedge clk);
        rd_id = id;
        #1;
        chk("rd_tank_pos",    32'(rd_tank_pos),    32'(t_pos));
        chk("rd_proj_pos",    32'(rd_proj_pos),    32'(p_pos));
        chk("rd_proj_active", 32'(rd_proj_active), 32'(act));
        chk("rd_score",       32'(rd_score),       32'(sc));
    endtask

    task automatic check_reset_state();
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_pos",     32'(rsp_pos),     32'd0);
        chk("rst_rsp_dir",     32'(rsp_dir),     32'd0);
        chk("rst_rsp_blocked", 32'(rsp_blocked), 32'd0);
        chk("rst_rsp_hit",     32'(rsp_hit),     32'd0);
        chk("rst_rsp_victim",  32'(rsp_victim),  32'd0);
        check_rd(0, 8'h00, 8'h00, 1'b0, 4'd0);
        check_rd(1, 8'hFF, 8'hFF, 1'b0, 4'd0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_id = '0; cmd_dir = 2'b00; rd_id = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
        check_reset_state();

        // Basic moves and the top edge.
        do_cmd(MV, 0, DN, 8'h10, DN, 1'b0, 1'b0, 0);
        do_cmd(MV, 0, UP, 8'h00, UP, 1'b0, 1'b0, 0);
        do_cmd(MV, 0, UP, 8'h00, UP, 1'b1, 1'b0, 0);
        do_cmd(MV, 0, DN, 8'h10, DN, 1'b0, 1'b0, 0);

        // Walk tank1 from 0xFF to 0x11.
        for (int k = 1; k <= 14; k++)
            do_cmd(MV, 1, LT, {4'hF, 4'(15 - k)}, LT, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 14; k++)
            do_cmd(MV, 1, UP, {4'(15 - k), 4'h1}, UP, 1'b0, 1'b0, 0);

        // Tank-to-tank blocking from both sides.
        do_cmd(MV, 0, RT, 8'h10, RT, 1'b1, 1'b0, 0);
        do_cmd(MV, 1, LT, 8'h11, LT, 1'b1, 1'b0, 0);
        check_rd(0, 8'h10, 8'h10, 1'b0, 4'd0);
        check_rd(1, 8'h11, 8'h11, 1'b0, 4'd0);

        // Tank0 at 0x00 facing right, tank1 at 0x02.
        do_cmd(MV, 0, UP, 8'h00, UP, 1'b0, 1'b0, 0);
        do_cmd(TN, 0, RT, 8'h00, RT, 1'b0, 1'b0, 0);
        do_cmd(MV, 1, UP, 8'h01, UP, 1'b0, 1'b0, 0);
        do_cmd(MV, 1, RT, 8'h02, RT, 1'b0, 1'b0, 0);

        // Fire, refire blocked, step, hit.
        do_cmd(SP, 0, UP, 8'h00, RT, 1'b0, 1'b0, 0);
        do_cmd(FR, 0, UP, 8'h00, RT, 1'b0, 1'b0, 0);
        check_rd(0, 8'h00, 8'h00, 1'b1, 4'd0);
        do_cmd(FR, 0, DN, 8'h00, RT, 1'b1, 1'b0, 0);
        do_cmd(SP, 0, UP, 8'h01, RT, 1'b0, 1'b0, 0);
        check_rd(0, 8'h00, 8'h01, 1'b1, 4'd0);
        do_cmd(FR, 0, LT, 8'h01, RT, 1'b1, 1'b0, 0);
        do_cmd(SP, 0, UP, 8'h02, RT, 1'b0, 1'b1, 1);
        check_rd(0, 8'h00, 8'h00, 1'b0, 4'd1);
        check_rd(1, 8'h02, 8'h02, 1'b0, 4'd0);

        // Projectile flies to col 15 and dies on the next step.
        do_cmd(MV, 1, DN, 8'h12, DN, 1'b0, 1'b0, 0);
        do_cmd(FR, 0, UP, 8'h00, RT, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 15; k++)
            do_cmd(SP, 0, UP, {4'h0, 4'(k)}, RT, 1'b0, 1'b0, 0);
        do_cmd(SP, 0, UP, 8'h0F, RT, 1'b0, 1'b0, 0);
        check_rd(0, 8'h00, 8'h00, 1'b0, 4'd1);

        // Score saturation: tank1 parked at 0x01, repeated point-blank hits.
        do_cmd(MV, 1, UP, 8'h02, UP, 1'b0, 1'b0, 0);
        do_cmd(MV, 1, LT, 8'h01, LT, 1'b0, 1'b0, 0);
        for (int r = 2; r <= 16; r++) begin
            do_cmd(FR, 0, UP, 8'h00, RT, 1'b0, 1'b0, 0);
            do_cmd(SP, 0, UP, 8'h01, RT, 1'b0, 1'b1, 1);
            check_rd(0, 8'h00, 8'h00, 1'b0, 4'((r > 15) ? 15 : r));
        end

        // Tank1 shoots tank0.
        do_cmd(FR, 1, UP, 8'h01, LT, 1'b0, 1'b0, 0);
        do_cmd(SP, 1, UP, 8'h00, LT, 1'b0, 1'b1, 0);
        check_rd(1, 8'h01, 8'h01, 1'b0, 4'd1);

        // Reset during CALC abandons the command and restores reset values.
        cmd_op = MV; cmd_id = 1; cmd_dir = RT; cmd_valid = 1'b1;
        #1;
        chk("pre_abort_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        check_reset_state();

        // Normal operation after the abort.
        do_cmd(MV, 1, LT, 8'hFE, LT, 1'b0, 1'b0, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
